// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares the gate-level 4:1 mux between four requesters.
// Optional build macro ARB_PRIO0_EN: channel 0 wins every arbitration point it requests.

module mux (
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic [1:0] s,
  output logic       m
);
  assign m = (~s[1] & ~s[0] & i0) |
             (~s[1] &  s[0] & i1) |
             ( s[1] & ~s[0] & i2) |
             ( s[1] &  s[0] & i3);
endmodule

module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       m,
  output logic       m_valid,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             m_q, m_d;
  logic             m_valid_q, m_valid_d;
  logic             mux_y;
  logic [1:0]       winner;
  logic             own_req, other_req;

  mux u_mux (
    .i0 (i0),
    .i1 (i1),
    .i2 (i2),
    .i3 (i3),
    .s  (sel_q),
    .m  (mux_y)
  );

  // Search starts just after 'from' and wraps round, so 'from' itself is checked last.
  function automatic logic [1:0] pick_winner(input logic [1:0] from, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    pick_winner = from;
    found       = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = from + 2'(i);
      if (r[idx] && !found) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
`ifdef ARB_PRIO0_EN
    if (r[0]) pick_winner = 2'd0;
`endif
  endfunction

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      hold_q    <= '0;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      m_q       <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign own_req   = |(req & gnt_q);
  assign other_req = |(req & ~gnt_q);

  // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    m_d       = m_q;
    m_valid_d = 1'b0;
    winner    = 2'd0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          winner  = pick_winner(last_q, req);
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = 4'b0001 << winner;
          hold_d  = '0;
        end
      end
      GRANT: begin
        m_d       = mux_y;
        m_valid_d = 1'b1;
        if (own_req) begin
          if (hold_q == HOLD_LAST && other_req) begin
            last_d = sel_q;
            winner = pick_winner(sel_q, req);
            sel_d  = winner;
            gnt_d  = 4'b0001 << winner;
            hold_d = '0;
          end else begin
            hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + 1'b1;
          end
        end else begin
          last_d = sel_q;
          if (|req) begin
            // Hand-over in the same edge keeps the mux busy with no idle bubble.
            winner = pick_winner(sel_q, req);
            sel_d  = winner;
            gnt_d  = 4'b0001 << winner;
            hold_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt     = gnt_q;
    sel     = sel_q;
    m       = m_q;
    m_valid = m_valid_q;
    busy    = (state_q == GRANT);
  end

endmodule
